// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master that runs one host command at a time as a single read or write transaction.
// Each wait phase has a watchdog, so every accepted command produces exactly one response.
`timescale 1ns/1ps
module axi_lite_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          FORCE_ALIGN    = 1'b1
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_timeout;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_any_hs;
  logic                w_wait;
  logic                w_expire;
  logic                w_aw_left;
  logic                w_w_left;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [ADDR_W-1:0]   w_addr_in;

  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid  & M_AXI_WREADY;
  assign w_b_hs    = r_bready  & M_AXI_BVALID;
  assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
  assign w_r_hs    = r_rready  & M_AXI_RVALID;
  assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_aw_left = r_awvalid & ~M_AXI_AWREADY;
  assign w_w_left  = r_wvalid  & ~M_AXI_WREADY;
  assign w_wait    = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // A zero limit disables the watchdog; a handshake in the same cycle always wins.
  assign w_expire  = (TO_LIMIT != '0) && (w_cnt_inc == TO_LIMIT) && !w_any_hs;
  assign w_addr_in = FORCE_ALIGN ? {cmd_addr[ADDR_W-1:2], 2'b00} : cmd_addr;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_cnt       <= '0;
          if (r_cmd_ready && cmd_valid) begin
            r_addr      <= w_addr_in;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (!w_aw_left && !w_w_left) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_bready      <= 1'b0;
            r_rsp_resp    <= M_AXI_BRESP;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_rready      <= 1'b0;
            r_rsp_resp    <= M_AXI_RRESP;
            r_rsp_rdata   <= M_AXI_RDATA;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wait) begin
        r_cnt <= w_any_hs ? '0 : w_cnt_inc;
      end

      // Watchdog abort overrides whatever the phase logic above scheduled.
      if (w_wait && w_expire) begin
        r_awvalid     <= 1'b0;
        r_wvalid      <= 1'b0;
        r_bready      <= 1'b0;
        r_arvalid     <= 1'b0;
        r_rready      <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_resp    <= RESP_SLVERR;
        r_rsp_rdata   <= '0;
        r_cnt         <= '0;
        r_state       <= S_RSP;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed and random commands against a delay-programmable AXI slave,
// with expected responses, timing and handshake shapes derived from the command and slave settings.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration, written by the stimulus block only.
  int          aw_d, w_d, b_d, ar_d, r_d;
  bit          aw_en, w_en, b_en, ar_en, r_en;
  logic [1:0]  bresp_c, rresp_c;
  logic [31:0] rdata_c;

  axi_lite_cmd_master #(.TIMEOUT_CYCLES(TO), .FORCE_ALIGN(1'b1)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: settles the previous rising edge's handshakes, then drives new ready/valid for the next edge.
  initial begin
    int  aw_c, w_c, ar_c, b_c, r_c;
    bit  aw_done, w_done, rd_pend, s_aw, s_w, s_b, s_ar, s_r;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    aw_done = 0; w_done = 0; rd_pend = 0; s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        aw_done = 0; w_done = 0; rd_pend = 0; s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
      end else begin
        if (s_aw && awready) aw_done = 1;
        if (s_w && wready)   w_done = 1;
        if (s_b && bvalid)   bvalid = 0;
        if (s_ar && arready) rd_pend = 1;
        if (s_r && rvalid)   rvalid = 0;
        s_aw = awvalid; s_w = wvalid; s_b = bready; s_ar = arvalid; s_r = rready;
        if (awvalid && aw_en) begin awready = (aw_c >= aw_d); aw_c++; end
        else begin awready = 0; aw_c = 0; end
        if (wvalid && w_en) begin wready = (w_c >= w_d); w_c++; end
        else begin wready = 0; w_c = 0; end
        if (arvalid && ar_en) begin arready = (ar_c >= ar_d); ar_c++; end
        else begin arready = 0; ar_c = 0; end
        if (aw_done && w_done && b_en && !bvalid) begin
          if (b_c >= b_d) begin bvalid = 1; bresp = bresp_c; aw_done = 0; w_done = 0; b_c = 0; end
          else b_c++;
        end
        if (rd_pend && r_en && !rvalid) begin
          if (r_c >= r_d) begin rvalid = 1; rdata = rdata_c; rresp = rresp_c; rd_pend = 0; r_c = 0; end
          else r_c++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge of the first cycle after acceptance.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  task automatic wait_rsp(input bit wr, input int exp_k, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, input bit exp_to, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                          input int exp_a_last, input int exp_w_last, input int exp_rdy_first,
                          input int bp);
    int k = 1, aw_last = 0, w_last = 0, ar_last = 0, rdy_first = 0;
    bit stable = 1, hold_ok;
    logic [34:0] snap;
    check("busy_active", 32'(busy), 32'd1);
    while (rsp_valid !== 1'b1 && k < 200) begin
      if (awvalid) begin aw_last = k; if (awaddr !== exp_addr) stable = 0; end
      if (wvalid)  begin w_last = k;  if (wdata !== exp_wdata || wstrb !== exp_wstrb) stable = 0; end
      if (arvalid) begin ar_last = k; if (araddr !== exp_addr) stable = 0; end
      if ((bready || rready) && rdy_first == 0) rdy_first = k;
      @(negedge clk); k++;
    end
    check("rsp_latency", 32'(k), 32'(exp_k));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp_timeout", 32'({rsp_resp, rsp_timeout}), 32'({exp_resp, exp_to}));
    check("axi_quiet_at_rsp", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("addr_valid_last", 32'(wr ? aw_last : ar_last), 32'(exp_a_last));
    check("wvalid_last", 32'(w_last), 32'(exp_w_last));
    check("ready_first", 32'(rdy_first), 32'(exp_rdy_first));
    check("payload_stable", 32'(stable), 32'd1);
    snap = {rsp_rdata, rsp_resp, rsp_timeout};
    hold_ok = (cmd_ready === 1'b0);
    repeat (bp) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_resp, rsp_timeout} !== snap || cmd_ready !== 1'b0)
        hold_ok = 0;
    end
    check("rsp_hold", 32'(hold_ok), 32'd1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("idle_after_rsp", 32'({cmd_ready, busy, rsp_valid}), 32'b100);
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd, input logic [1:0] br,
                           input bit b_never, input int bp);
    int m = (awd > wd) ? awd : wd;
    logic [31:0] al = a & 32'hFFFF_FFFC;
    aw_d = awd; w_d = wd; b_d = bd; bresp_c = br; b_en = !b_never;
    send_cmd(1'b1, a, d, s);
    if (b_never) wait_rsp(1'b1, 2 + m + TO, 32'd0, 2'b10, 1'b1, al, d, s, 1 + awd, 1 + wd, 2 + m, bp);
    else         wait_rsp(1'b1, 3 + m + bd, 32'd0, br, 1'b0, al, d, s, 1 + awd, 1 + wd, 2 + m, bp);
  endtask

  task automatic run_read(input logic [31:0] a, input logic [31:0] rd, input int ard, input int rdd,
                          input logic [1:0] rr, input bit ar_never, input int bp);
    logic [31:0] al = a & 32'hFFFF_FFFC;
    ar_d = ard; r_d = rdd; rdata_c = rd; rresp_c = rr; ar_en = !ar_never;
    send_cmd(1'b0, a, 32'd0, 4'd0);
    if (ar_never) wait_rsp(1'b0, 1 + TO, 32'd0, 2'b10, 1'b1, al, 32'd0, 4'd0, TO, 0, 0, bp);
    else          wait_rsp(1'b0, 3 + ard + rdd, rd, rr, 1'b0, al, 32'd0, 4'd0, 1 + ard, 0, 2 + ard, bp);
  endtask

  initial begin
    int guard;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    aw_en = 1; w_en = 1; b_en = 1; ar_en = 1; r_en = 1;
    bresp_c = 0; rresp_c = 0; rdata_c = 0;
    repeat (3) @(negedge clk);
    check("reset_axi_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_flags", 32'({rsp_valid, rsp_timeout, busy, rsp_resp}), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    run_write(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0, 0);
    run_read (32'h0000_0083, 32'h1234_5678, 2, 3, 2'b00, 1'b0, 0);
    run_write(32'h0000_0100, 32'hA5A5_5A5A, 4'h3, 0, 3, 0, 2'b00, 1'b0, 1);
    run_read (32'h0000_0200, 32'h0BAD_0BAD, 0, 0, 2'b00, 1'b1, 0);
    ar_en = 1;
    run_read (32'h0000_0010, 32'hCAFE_F00D, 0, 0, 2'b00, 1'b0, 5);
    run_write(32'h0000_0044, 32'h0000_0001, 4'h1, 1, 0, 2, 2'b10, 1'b0, 0);
    run_read (32'h0000_0FFE, 32'h7777_0000, 1, 1, 2'b11, 1'b0, 2);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_write($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5),
                  $urandom_range(0, 5), $urandom_range(0, 5), 2'($urandom_range(0, 3)), 1'b0,
                  $urandom_range(0, 3));
      else
        run_read($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
                 2'($urandom_range(0, 3)), 1'b0, $urandom_range(0, 3));
    end

    run_write(32'h0000_0300, 32'h1111_2222, 4'hC, 2, 1, 0, 2'b00, 1'b1, 0);

    // Abort while waiting for the write response; slave never answers this one.
    aw_d = 0; w_d = 0; b_en = 0;
    send_cmd(1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'hF);
    guard = 0;
    while (bready !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    check("reached_wr_resp", 32'(bready), 32'd1);
    #2 rst_n = 0;
    #1 check("async_abort", 32'({bready, rsp_valid, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    b_en = 1;
    run_read(32'h0000_0404, 32'h600D_D00D, 1, 0, 2'b00, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI4-Lite initiator that turns single-word commands from a host-side client (loader, debug bridge, testbench driver) into AXI4-Lite read or write transactions. It drives the CPU's AXI-Lite register and memory window (control, status, PC, register readback, instruction and data memory) as the single master on that bus. One transaction is outstanding at a time. A per-phase timeout guarantees that every accepted command produces exactly one response.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed per wait phase before abort; 0 disables the timeout; legal range 0..65535.
- FORCE_ALIGN, 1: when 1, bits [1:0] of AWADDR and ARADDR are forced to 0.

Ports:
- M_AXI_ACLK  in  1  clock; all logic is on the rising edge.
- M_AXI_ARESETN  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  captured BRESP or RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  response was produced by timeout.
- busy  out  1  high in every state except IDLE.
- M_AXI_AWADDR  out  32 / M_AXI_AWVALID  out  1 / M_AXI_AWREADY  in  1: write address channel.
- M_AXI_WDATA  out  32 / M_AXI_WSTRB  out  4 / M_AXI_WVALID  out  1 / M_AXI_WREADY  in  1: write data channel.
- M_AXI_BRESP  in  2 / M_AXI_BVALID  in  1 / M_AXI_BREADY  out  1: write response channel.
- M_AXI_ARADDR  out  32 / M_AXI_ARVALID  out  1 / M_AXI_ARREADY  in  1: read address channel.
- M_AXI_RDATA  in  32 / M_AXI_RRESP  in  2 / M_AXI_RVALID  in  1 / M_AXI_RREADY  out  1: read data channel.

## Operation
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- **IDLE:** cmd_ready = 1. On cmd_valid, register the address (aligned when FORCE_ALIGN = 1), data and strobes.
  - cmd_write = 1: go to WR_REQ with AWVALID = 1 and WVALID = 1.
  - cmd_write = 0: go to RD_REQ with ARVALID = 1.
- **WR_REQ:**
  - AW and W complete independently; each VALID drops the cycle after its own handshake.
  - The other VALID, address and data stay stable until that channel's handshake.
  - When both channels are done (including both on the same cycle), go to WR_RESP with BREADY = 1.
- **WR_RESP:** on BVALID, capture BRESP, drop BREADY, set rsp_rdata = 0, go to RSP.
- **RD_REQ:** on ARREADY, drop ARVALID, go to RD_DATA with RREADY = 1.
- **RD_DATA:** on RVALID, capture RDATA and RRESP, drop RREADY, go to RSP.
- **RSP:**
  - rsp_valid = 1 and all rsp_* outputs are held stable.
  - cmd_ready = 0.
  - On rsp_ready, go to IDLE.
- **Timeout counter (16-bit):**
  - Cleared on command acceptance and on every AXI handshake; increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When the count reaches TIMEOUT_CYCLES with no handshake in that cycle: deassert every VALID and READY, set rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0, go to RSP.
  - After a timeout, a late BVALID or RVALID is not accepted (READY stays low until a later command reaches its response phase).
- **Errors:** SLVERR or DECERR responses are passed through unchanged in rsp_resp with rsp_timeout = 0.

## Timing
- **Reset values:** all VALID and READY outputs 0; cmd_ready 0 while reset is asserted, then 1 in IDLE; rsp_valid 0; rsp_rdata 0; rsp_resp 0; rsp_timeout 0; busy 0; state IDLE; counter 0.
- **Reset mid-transaction:** the block aborts immediately and asynchronously; no response is produced for the lost command.
- **AXI outputs:** all registered; VALID never depends combinationally on READY.
- **Write latency:** command accepted at cycle N; AW and W VALID at N+1. If AWREADY, WREADY and BVALID are all high: AW/W handshake at N+1, BREADY at N+2, B handshake at N+2, rsp_valid at N+3.
- **Read latency:** ARVALID at N+1. With ARREADY and RVALID high: AR handshake at N+1, R handshake at N+2, rsp_valid at N+3.
- **Back-to-back commands:** the next command can be accepted one cycle after the response handshake (back in IDLE).
- **Timeout latency:** rsp_valid rises exactly TIMEOUT_CYCLES + 1 cycles after the last clear, when no handshake occurs.

## Test plan
- **Write:** cmd write addr 0x0000_0040, data 0xDEADBEEF, strb 0xF; slave always ready, BRESP 00. Required: AWADDR 0x40, WDATA 0xDEADBEEF, WSTRB 0xF; rsp_valid at N+3 with rsp_resp 00, rsp_timeout 0.
- **Read with slave wait states:** cmd read addr 0x0000_0083 with FORCE_ALIGN = 1; slave ARREADY after 2 cycles, RVALID 3 cycles later with RDATA 0x12345678. Required: ARADDR 0x80; rsp_rdata 0x12345678, rsp_resp 00.
- **Skewed write handshakes:** AWREADY at cycle N+1, WREADY at N+4. Required: AWVALID low from N+2; WVALID held with stable WDATA until N+4; BREADY asserted at N+5.
- **Timeout:** TIMEOUT_CYCLES = 16, slave never asserts ARREADY. Required: ARVALID drops after 16 cycles; rsp_timeout 1, rsp_resp 2'b10, rsp_rdata 0.
- **Response backpressure:** rsp_ready held low for 5 cycles after a read with RDATA 0xCAFEF00D. Required: rsp_valid and rsp_rdata held stable; cmd_ready 0 throughout; IDLE reached one cycle after rsp_ready.
- **Reset mid-transaction:** assert M_AXI_ARESETN low while in WR_RESP. Required: BREADY, rsp_valid and busy go to 0 immediately; after release, the next read completes normally.
